detect_event_monitor: RTL and testbench
=======================================

# detect_event_monitor

Downstream consumer of the 11011 sequence detector's one-cycle detect pulse inside the Tiny Tapeout top. It counts detection events and flags counter overflow, so the count survives past the detector's single-cycle output. It stretches each event into a visible LED pulse and measures detections per fixed time window. Outputs drive the spare `uo_out[7:1]` / `uio_out` pins.

## Interface
Parameters:
- `CNT_W`, 7, width of the total and per-window event counters.
- `STRETCH`, 4, number of cycles `led_o` stays high per event (≥1).
- `WINDOW`, 256, rate window length in clock cycles (≥2).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset. The top drives it as `~rst_n`.
- `detect_in`  in  1  event strobe from the sequence detector. It may be combinational from the Mealy output and is sampled on the clock edge. Every high cycle counts as one event.
- `clear`  in  1  synchronous clear of counters, window and flags.
- `count_o`  out  CNT_W  total events since reset/clear, saturating.
- `overflow_o`  out  1  sticky; set when an event arrives while `count_o` is all-ones.
- `led_o`  out  1  stretched event indicator.
- `rate_o`  out  CNT_W  event count of the last completed window, saturating.
- `rate_valid_o`  out  1  one-cycle strobe: `rate_o` just updated.

## Operation
- Reset values: `count_o`=0, `overflow_o`=0, `led_o`=0, `rate_o`=0, `rate_valid_o`=0, window timer=0, window count=0, stretcher in IDLE.
- Total counter:
  - On `detect_in`=1, increment `count_o`.
  - At 2^CNT_W−1 it holds, and `overflow_o` is set and remains set until `rst` or `clear`.
- Stretcher FSM, states IDLE and HOLD, down-counter `hold_cnt`:
  - IDLE + detect → HOLD, `hold_cnt`=STRETCH−1.
  - HOLD + detect → stay in HOLD and reload `hold_cnt`=STRETCH−1 (retrigger).
  - HOLD, no detect, `hold_cnt`=0 → IDLE.
  - Otherwise in HOLD, decrement `hold_cnt`.
  - `led_o` is registered and high exactly while in HOLD.
- Window:
  - Free-running timer counts 0..WINDOW−1 and wraps.
  - Window count increments on detect and saturates at 2^CNT_W−1.
  - On the cycle the timer equals WINDOW−1:
    - `rate_o` ← window count + detect_in, saturated.
    - Window count ← 0.
    - `rate_valid_o` ← 1 for the next cycle only.
  - A detect on the final window cycle belongs to the closing window.
- `clear`:
  - Zeroes `count_o`, `overflow_o`, window timer, window count and `rate_o`, and forces `rate_valid_o`=0.
  - It does not affect the stretcher.
  - When `clear` and `detect_in` are high in the same cycle, clear wins for the counters, and that event is not counted anywhere.
  - The stretcher still triggers on that same detect.

## Timing
- All outputs are registered, with no combinational input→output path.
- Latency: `detect_in` high in cycle N gives `count_o`+1 and `led_o`=1 visible in cycle N+1.
- A single isolated event drives `led_o` high for cycles N+1..N+STRETCH.
- Back-to-back detects (cycles N and N+1) count 2, and `led_o` stays high through cycle N+1+STRETCH.
- A window ending in cycle W gives `rate_o` and `rate_valid_o` in cycle W+1.
- The first window after reset or clear ends WINDOW cycles after the release edge.
- Asserting `rst` mid-operation drops all outputs to their reset values immediately, without waiting for a clock. The first window restarts on release.

## Structure
- Shared package `detect_mon_pkg`: stretcher state enum (IDLE, HOLD) and default parameter constants.
- Sub-module `pulse_stretcher`: the IDLE/HOLD FSM plus `hold_cnt`, parameterised by STRETCH.
- The counters, window timer and flags stay in the top of `detect_event_monitor`.

## Test plan
- Reset check: assert `rst` asynchronously mid-HOLD with `count_o`=5. All outputs must read 0 before the next edge. After release, the first `rate_valid_o` must appear 256 cycles later with `rate_o`=0.
- Isolated pulse: one `detect_in` cycle. Required: `count_o`=1 next cycle, and `led_o` high for exactly 4 cycles.
- Retrigger: detects at cycles 0 and 2. Required: `count_o`=2, and `led_o` high continuously for cycles 1..6.
- Saturation: 130 detects. Required: `count_o`=127 and `overflow_o`=1. `clear` must then return both to 0.
- Window: 3 detects in a window, one of them on the final window cycle. Required: `rate_o`=3 with a single-cycle `rate_valid_o`, and the next window starts from 0.
- Clear collision: `clear`+`detect_in` in the same cycle with `count_o`=9. Required: `count_o`=0 next cycle, and `led_o` still rises.

Source files
------------

// File: rtl/detect_mon_pkg.sv
// Shared types and default parameters for the detect-event monitor slice.
// Imported by the interface, the stretcher and the top.
package detect_mon_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } stretch_state_e;

   localparam int DEF_CNT_W   = 7;
   localparam int DEF_STRETCH = 4;
   localparam int DEF_WINDOW  = 256;

endpackage : detect_mon_pkg

// File: rtl/detect_event_monitor_if.sv
// Event-strobe/result bundle between the sequence detector side and the monitor.
// The master drives detect_in/clear; the slave (the monitor) returns the results.
interface detect_event_monitor_if
   import detect_mon_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);

   logic             detect_in;
   logic             clear;
   logic [CNT_W-1:0] count_o;
   logic             overflow_o;
   logic             led_o;
   logic [CNT_W-1:0] rate_o;
   logic             rate_valid_o;

   modport master (
      output detect_in,
      output clear,
      input  count_o,
      input  overflow_o,
      input  led_o,
      input  rate_o,
      input  rate_valid_o
   );

   modport slave (
      input  detect_in,
      input  clear,
      output count_o,
      output overflow_o,
      output led_o,
      output rate_o,
      output rate_valid_o
   );

endinterface : detect_event_monitor_if

// File: rtl/pulse_stretcher.sv
// IDLE/HOLD stretcher: each detect holds led_o high for STRETCH cycles,
// and a detect during HOLD restarts the hold period.
module pulse_stretcher
   import detect_mon_pkg::*;
#(
   parameter int STRETCH = DEF_STRETCH
) (
   input  logic clk,
   input  logic rst,
   input  logic detect_i,
   output logic led_o
);

   localparam int                HOLD_W = (STRETCH > 1) ? $clog2(STRETCH) : 1;
   localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(STRETCH - 1);

   stretch_state_e    state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   // NOTE: state registers take non-blocking assignments only, so every flop
   // samples the pre-edge values of its neighbours regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // NOTE: defaults are assigned before the case so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (detect_i) begin
               state_d    = ST_HOLD;
               hold_cnt_d = RELOAD;
            end
         end
         ST_HOLD: begin
            if (detect_i) begin
               hold_cnt_d = RELOAD;
            end else if (hold_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
         end
      endcase
   end

   assign led_o = (state_q == ST_HOLD);

endmodule : pulse_stretcher

// File: rtl/detect_event_monitor.sv
// Counts detector events (saturating, sticky overflow), stretches them for an
// LED and reports the event count of each fixed-length time window.
module detect_event_monitor
   import detect_mon_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int STRETCH = DEF_STRETCH,
   parameter int WINDOW  = DEF_WINDOW
) (
   input logic                   clk,
   input logic                   rst,
   detect_event_monitor_if.slave bus
);

   localparam int                 TIMER_W    = $clog2(WINDOW);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

   logic [CNT_W-1:0]   count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0]   rate_q, rate_d;
   logic               rate_valid_q, rate_valid_d;
   logic [CNT_W-1:0]   win_sum;
   logic               win_end;
   logic               led;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q      <= '0;
         overflow_q   <= 1'b0;
         timer_q      <= '0;
         win_cnt_q    <= '0;
         rate_q       <= '0;
         rate_valid_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         timer_q      <= timer_d;
         win_cnt_q    <= win_cnt_d;
         rate_q       <= rate_d;
         rate_valid_q <= rate_valid_d;
      end
   end

   assign win_end = (timer_q == TIMER_LAST);
   // A detect on the closing cycle still belongs to the closing window.
   assign win_sum = (bus.detect_in && (win_cnt_q != CNT_MAX)) ? win_cnt_q + 1'b1 : win_cnt_q;

   always_comb begin
      count_d      = count_q;
      overflow_d   = overflow_q;
      timer_d      = win_end ? '0 : timer_q + 1'b1;
      win_cnt_d    = win_sum;
      rate_d       = rate_q;
      rate_valid_d = 1'b0;

      if (bus.clear) begin
         count_d    = '0;
         overflow_d = 1'b0;
         timer_d    = '0;
         win_cnt_d  = '0;
         rate_d     = '0;
      end else begin
         if (bus.detect_in) begin
            if (count_q == CNT_MAX) begin
               overflow_d = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         if (win_end) begin
            rate_d       = win_sum;
            win_cnt_d    = '0;
            rate_valid_d = 1'b1;
         end
      end
   end

   // The stretcher ignores clear: a clear+detect cycle still lights the LED.
   pulse_stretcher #(
      .STRETCH (STRETCH)
   ) u_stretcher (
      .clk      (clk),
      .rst      (rst),
      .detect_i (bus.detect_in),
      .led_o    (led)
   );

   assign bus.count_o      = count_q;
   assign bus.overflow_o   = overflow_q;
   assign bus.led_o        = led;
   assign bus.rate_o       = rate_q;
   assign bus.rate_valid_o = rate_valid_q;

endmodule : detect_event_monitor

// File: tb/tb_detect_event_monitor.sv
// Directed and randomized bench for detect_event_monitor against an
// event-history reference model.
module tb_detect_event_monitor;

   localparam int CNT_W   = 7;
   localparam int STRETCH = 4;
   localparam int WINDOW  = 256;
   localparam int MAXV    = (1 << CNT_W) - 1;

   logic clk;
   logic rst;

   detect_event_monitor_if #(.CNT_W(CNT_W)) bus ();

   detect_event_monitor #(
      .CNT_W   (CNT_W),
      .STRETCH (STRETCH),
      .WINDOW  (WINDOW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks   = 0;
   int failures = 0;

   // Reference model: event history expressed as edge indices and plain counts.
   int e;           // index of the next clock edge since reset release
   int win_start;   // edge index at which the current window began
   int win_events;  // events seen in the current window so far
   int last_det;    // edge index of the most recent detect
   bit has_det;
   int m_count, m_rate;
   bit m_ovf, m_valid, m_led;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      e          = 0;
      win_start  = 0;
      win_events = 0;
      last_det   = 0;
      has_det    = 1'b0;
      m_count    = 0;
      m_rate     = 0;
      m_ovf      = 1'b0;
      m_valid    = 1'b0;
      m_led      = 1'b0;
   endtask

   task automatic model_update(input bit det, input bit clr);
      if (clr) begin
         m_count    = 0;
         m_ovf      = 1'b0;
         m_rate     = 0;
         m_valid    = 1'b0;
         win_events = 0;
         win_start  = e + 1;
      end else begin
         if (det) begin
            if (m_count == MAXV) m_ovf = 1'b1;
            else                 m_count = m_count + 1;
         end
         if ((e - win_start) % WINDOW == WINDOW - 1) begin
            m_rate     = (win_events + int'(det) > MAXV) ? MAXV : win_events + int'(det);
            m_valid    = 1'b1;
            win_events = 0;
         end else begin
            m_valid    = 1'b0;
            win_events = win_events + int'(det);
         end
      end
      if (det) begin
         last_det = e;
         has_det  = 1'b1;
      end
      m_led = has_det && ((e - last_det) < STRETCH);
   endtask

   task automatic compare_all();
      check("count_o",      bus.count_o,      m_count);
      check("overflow_o",   bus.overflow_o,   m_ovf);
      check("led_o",        bus.led_o,        m_led);
      check("rate_o",       bus.rate_o,       m_rate);
      check("rate_valid_o", bus.rate_valid_o, m_valid);
   endtask

   // One clock cycle: drive inputs, let the edge happen, check #1 after it.
   task automatic step(input bit det, input bit clr);
      bus.detect_in = det;
      bus.clear     = clr;
      @(posedge clk);
      model_update(det, clr);
      #1;
      compare_all();
      e++;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_count"}, bus.count_o,      0);
      check({tag, "_ovf"},   bus.overflow_o,   0);
      check({tag, "_led"},   bus.led_o,        0);
      check({tag, "_rate"},  bus.rate_o,       0);
      check({tag, "_valid"}, bus.rate_valid_o, 0);
   endtask

   initial begin
      int first_valid;
      int led_cycles;
      int led_first;
      int led_last;

      rst           = 1'b1;
      bus.detect_in = 1'b0;
      bus.clear     = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check_all_zero("por");
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Asynchronous reset in the middle of a HOLD with count 5.
      repeat (5) step(1'b1, 1'b0);
      check("pre_rst_count", bus.count_o, 5);
      check("pre_rst_led",   bus.led_o,   1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      first_valid = 0;
      for (int i = 1; i <= WINDOW + 40; i++) begin
         step(1'b0, 1'b0);
         if (bus.rate_valid_o === 1'b1) begin
            first_valid = i;
            break;
         end
      end
      check("first_window_cycles", first_valid, WINDOW);
      check("first_window_rate",   bus.rate_o,  0);

      // Isolated pulse.
      step(1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check("iso_count", bus.count_o, 1);
      led_cycles = int'(bus.led_o);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0);
         led_cycles += int'(bus.led_o);
      end
      check("iso_led_cycles", led_cycles, STRETCH);

      // Retrigger: detects at relative cycles 0 and 2.
      step(1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0);
      led_first  = -1;
      led_last   = -1;
      led_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         step((i == 0) || (i == 2), 1'b0);
         if (bus.led_o === 1'b1) begin
            if (led_first < 0) led_first = i + 1;
            led_last = i + 1;
            led_cycles++;
         end
      end
      check("retrig_count",     bus.count_o, 2);
      check("retrig_led_first", led_first,   1);
      check("retrig_led_last",  led_last,    2 + STRETCH);
      check("retrig_led_cont",  led_cycles,  2 + STRETCH);

      // Saturation and sticky overflow.
      step(1'b0, 1'b1);
      repeat (130) step(1'b1, 1'b0);
      check("sat_count", bus.count_o,    MAXV);
      check("sat_ovf",   bus.overflow_o, 1);
      step(1'b0, 1'b0);
      check("sat_ovf_sticky", bus.overflow_o, 1);
      step(1'b0, 1'b1);
      check("sat_clr_count", bus.count_o,    0);
      check("sat_clr_ovf",   bus.overflow_o, 0);

      // Window of three events, the last on the closing cycle.
      step(1'b0, 1'b1);
      for (int i = 0; i < WINDOW; i++) begin
         step((i == 10) || (i == 100) || (i == WINDOW - 1), 1'b0);
      end
      check("win_rate",  bus.rate_o,       3);
      check("win_valid", bus.rate_valid_o, 1);
      step(1'b0, 1'b0);
      check("win_valid_drop", bus.rate_valid_o, 0);
      check("win_rate_hold",  bus.rate_o,       3);
      for (int i = 1; i < WINDOW; i++) step(1'b0, 1'b0);
      check("win_next_valid", bus.rate_valid_o, 1);
      check("win_next_rate",  bus.rate_o,       0);

      // Clear colliding with a detect.
      step(1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0);
      repeat (9) step(1'b1, 1'b0);
      repeat (STRETCH + 2) step(1'b0, 1'b0);
      check("coll_pre_count", bus.count_o, 9);
      check("coll_pre_led",   bus.led_o,   0);
      step(1'b1, 1'b1);
      check("coll_count", bus.count_o, 0);
      check("coll_led",   bus.led_o,   1);

      // Randomized traffic with occasional clears.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
      end
      repeat (300) step(1'b1, 1'b0);
      check("rand_sat_ovf", bus.overflow_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_detect_event_monitor
